// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen and its consumers.
// The generator drives the counters, syncs and strobes; the consumer
// supplies the pixel clock-enable.
interface vga_timing_gen_if #(
    parameter int CW = 10,
    parameter int FW = 8
);
    logic          ce;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          line_start;
    logic          frame_start;
    logic          vblank_start;
    logic [FW-1:0] frame_count;

    modport master (
        input  ce,
        output hcount, vcount, hsync, vsync, active,
        output line_start, frame_start, vblank_start, frame_count
    );

    modport slave (
        output ce,
        input  hcount, vcount, hsync, vsync, active,
        input  line_start, frame_start, vblank_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Every output is registered from the *next* counter value, so flags and
// counters change on the same edge with no skew. Reset parks the raster on
// the last pixel of the last line so the first enabled edge lands on (0,0).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 30,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10,
    parameter int FW       = 8
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_VBLANK = CW'(V_ACTIVE);

    // Counter width must be able to represent the last column and line.
    generate
        if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_cw_check
            $error("vga_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
        end
    endgenerate

    logic [CW-1:0] hcount_q, vcount_q;
    logic [CW-1:0] h_nxt, v_nxt;
    logic          hsync_q, vsync_q, active_q;
    logic          line_start_q, frame_start_q, vblank_start_q;
    logic [FW-1:0] frame_count_q;

    logic hs_on, vs_on, act_nxt;
    logic at_line, at_frame, at_vblank;

    // Next raster position: advance one pixel per enabled edge, wrapping line then frame.
    always_comb begin
        h_nxt = hcount_q;
        v_nxt = vcount_q;
        if (vga.ce) begin
            if (hcount_q == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                h_nxt = hcount_q + 1'b1;
            end
        end
    end

    // Flags decoded from the next position; strobes only fire on an actual move.
    always_comb begin
        hs_on     = (int'(h_nxt) >= HS_START) && (int'(h_nxt) < HS_END);
        vs_on     = (int'(v_nxt) >= VS_START) && (int'(v_nxt) < VS_END);
        act_nxt   = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
        at_line   = vga.ce && (h_nxt == '0);
        at_frame  = at_line && (v_nxt == '0);
        at_vblank = at_line && (v_nxt == V_VBLANK);
    end

    // Register counters, levels and one-cycle strobes together.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q       <= H_LAST;
            vcount_q       <= V_LAST;
            hsync_q        <= ~HS_POL;
            vsync_q        <= ~VS_POL;
            active_q       <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= '1;
        end else begin
            hcount_q       <= h_nxt;
            vcount_q       <= v_nxt;
            hsync_q        <= hs_on ? HS_POL : ~HS_POL;
            vsync_q        <= vs_on ? VS_POL : ~VS_POL;
            active_q       <= act_nxt;
            line_start_q   <= at_line;
            frame_start_q  <= at_frame;
            vblank_start_q <= at_vblank;
            if (at_frame) begin
                frame_count_q <= frame_count_q + 1'b1;
            end
        end
    end

    assign vga.hcount       = hcount_q;
    assign vga.vcount       = vcount_q;
    assign vga.hsync        = hsync_q;
    assign vga.vsync        = vsync_q;
    assign vga.active       = active_q;
    assign vga.line_start   = line_start_q;
    assign vga.frame_start  = frame_start_q;
    assign vga.vblank_start = vblank_start_q;
    assign vga.frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances (small, small inverted-polarity with
// 2-bit frame counter, default horizontal with short vertical, full default)
// share one clock. A linear pixel-index model predicts each edge's outputs into
// per-instance queues which are popped and compared after the edge.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp;
        bit hp, vp;
        int fw;
    } cfg_t;

    typedef struct packed {
        int h;
        int v;
        bit hs;
        bit vs;
        bit act;
        bit ls;
        bit fs;
        bit vbs;
        int fc;
    } exp_t;

    localparam int K_END = 16400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s, rst_p, rst_m, rst_d;
    logic ce_s, ce_p, ce_m, ce_d;

    vga_timing_gen_if #(.CW(4),  .FW(8)) vs ();
    vga_timing_gen_if #(.CW(4),  .FW(2)) vp ();
    vga_timing_gen_if #(.CW(10), .FW(8)) vm ();
    vga_timing_gen_if #(.CW(10), .FW(8)) vd ();

    assign vs.ce = ce_s;
    assign vp.ce = ce_p;
    assign vm.ce = ce_m;
    assign vd.ce = ce_d;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .FW(8)
    ) u_small (.clk(clk), .rst(rst_s), .vga(vs));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FW(2)
    ) u_pol (.clk(clk), .rst(rst_p), .vga(vp));

    vga_timing_gen #(
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2), .CW(10), .FW(8)
    ) u_med (.clk(clk), .rst(rst_m), .vga(vm));

    vga_timing_gen u_dflt (.clk(clk), .rst(rst_d), .vga(vd));

    cfg_t c_s = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 8};
    cfg_t c_p = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 2};
    cfg_t c_m = '{640, 16, 96, 48, 12, 2, 2, 2, 1'b0, 1'b0, 8};
    cfg_t c_d = '{640, 16, 96, 48, 480, 10, 2, 30, 1'b0, 1'b0, 8};

    int pos_s, pos_p, pos_m, pos_d;
    int fc_s, fc_p, fc_m, fc_d;
    exp_t q_s[$], q_p[$], q_m[$], q_d[$];
    exp_t o_s, o_p, o_m, o_d;

    int n_vec = 0;
    int n_err = 0;

    // Observed outputs flattened into the same shape as the model's prediction.
    always_comb begin
        o_s = '0;
        o_s.h = int'(vs.hcount); o_s.v = int'(vs.vcount);
        o_s.hs = vs.hsync; o_s.vs = vs.vsync; o_s.act = vs.active;
        o_s.ls = vs.line_start; o_s.fs = vs.frame_start; o_s.vbs = vs.vblank_start;
        o_s.fc = int'(vs.frame_count);
    end
    always_comb begin
        o_p = '0;
        o_p.h = int'(vp.hcount); o_p.v = int'(vp.vcount);
        o_p.hs = vp.hsync; o_p.vs = vp.vsync; o_p.act = vp.active;
        o_p.ls = vp.line_start; o_p.fs = vp.frame_start; o_p.vbs = vp.vblank_start;
        o_p.fc = int'(vp.frame_count);
    end
    always_comb begin
        o_m = '0;
        o_m.h = int'(vm.hcount); o_m.v = int'(vm.vcount);
        o_m.hs = vm.hsync; o_m.vs = vm.vsync; o_m.act = vm.active;
        o_m.ls = vm.line_start; o_m.fs = vm.frame_start; o_m.vbs = vm.vblank_start;
        o_m.fc = int'(vm.frame_count);
    end
    always_comb begin
        o_d = '0;
        o_d.h = int'(vd.hcount); o_d.v = int'(vd.vcount);
        o_d.hs = vd.hsync; o_d.vs = vd.vsync; o_d.act = vd.active;
        o_d.ls = vd.line_start; o_d.fs = vd.frame_start; o_d.vbs = vd.vblank_start;
        o_d.fc = int'(vd.frame_count);
    end

    task automatic chk_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmp(input string d, input exp_t o, input exp_t e);
        chk_val({d, ".hcount"}, o.h, e.h);
        chk_val({d, ".vcount"}, o.v, e.v);
        chk_val({d, ".hsync"}, int'(o.hs), int'(e.hs));
        chk_val({d, ".vsync"}, int'(o.vs), int'(e.vs));
        chk_val({d, ".active"}, int'(o.act), int'(e.act));
        chk_val({d, ".line_start"}, int'(o.ls), int'(e.ls));
        chk_val({d, ".frame_start"}, int'(o.fs), int'(e.fs));
        chk_val({d, ".vblank_start"}, int'(o.vbs), int'(e.vbs));
        chk_val({d, ".frame_count"}, o.fc, e.fc);
    endtask

    // Reference: raster position kept as a single pixel index within the frame.
    task automatic step(input cfg_t c, input logic r, input logic ce,
                        inout int pos, inout int fc, output exp_t e);
        int ht, vt, h, v;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        e = '0;
        if (r) begin
            pos = ht * vt - 1;
            fc  = (1 << c.fw) - 1;
        end else if (ce) begin
            pos   = (pos + 1) % (ht * vt);
            e.ls  = (pos % ht == 0);
            e.fs  = (pos == 0);
            e.vbs = (pos == c.va * ht);
            if (e.fs) fc = (fc + 1) % (1 << c.fw);
        end
        h = pos % ht;
        v = pos / ht;
        e.h   = h;
        e.v   = v;
        e.hs  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? c.hp : ~c.hp;
        e.vs  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? c.vp : ~c.vp;
        e.act = (h < c.ha) && (v < c.va);
        if (r) begin
            e.hs  = ~c.hp;
            e.vs  = ~c.vp;
            e.act = 1'b0;
        end
        e.fc = fc;
    endtask

    task automatic drive_push();
        exp_t e;
        step(c_s, rst_s, ce_s, pos_s, fc_s, e); q_s.push_back(e);
        step(c_p, rst_p, ce_p, pos_p, fc_p, e); q_p.push_back(e);
        step(c_m, rst_m, ce_m, pos_m, fc_m, e); q_m.push_back(e);
        step(c_d, rst_d, ce_d, pos_d, fc_d, e); q_d.push_back(e);
    endtask

    task automatic pop_cmp();
        chk_val("queue.depth", q_s.size() + q_p.size() + q_m.size() + q_d.size(), 4);
        if (q_s.size() > 0) cmp("small", o_s, q_s.pop_front());
        if (q_p.size() > 0) cmp("pol",   o_p, q_p.pop_front());
        if (q_m.size() > 0) cmp("med",   o_m, q_m.pop_front());
        if (q_d.size() > 0) cmp("dflt",  o_d, q_d.pop_front());
    endtask

    int fs_cyc_s[$];
    int pfc[$];
    int mfc[$];
    int n_ls = 0, n_wrap = 0, n_wide = 0, prev_h_s = 0;
    bit prev_ls = 1'b0, prev_fs = 1'b0, prev_vbs = 1'b0;
    int phs_min = 99, phs_max = -1;
    int mhs_min = 9999, mhs_max = -1, mvs_min = 9999, mvs_max = -1;
    int mvb_h = -1, mvb_v = -1;
    int rst_k = -1;

    initial begin
        pos_s = 0; pos_p = 0; pos_m = 0; pos_d = 0;
        fc_s = 0; fc_p = 0; fc_m = 0; fc_d = 0;
        rst_s = 1'b1; rst_p = 1'b1; rst_m = 1'b1; rst_d = 1'b1;
        ce_s = 1'b1; ce_p = 1'b1; ce_m = 1'b1; ce_d = 1'b1;

        // Reset with ce high: reset must win.
        for (int i = 0; i < 2; i++) begin
            drive_push();
            @(posedge clk); #1;
            pop_cmp();
            chk_val("pol.hsync_rst", int'(vp.hsync), 0);
            chk_val("pol.vsync_rst", int'(vp.vsync), 0);
        end
        rst_s = 1'b0; rst_p = 1'b0; rst_m = 1'b0; rst_d = 1'b0;

        for (int k = 1; k <= K_END; k++) begin
            if (k <= 60)       ce_s = 1'b1;
            else if (k <= 156) ce_s = ((k - 61) % 4 == 0) || ((k - 61) % 4 == 3);
            else               ce_s = 1'b1;
            rst_d = 1'b0;
            if (rst_k < 0 && pos_d == 20 * 800 + 300) begin
                rst_d = 1'b1;
                rst_k = k;
            end

            drive_push();
            @(posedge clk); #1;
            pop_cmp();

            if (k <= 60 && vs.frame_start) fs_cyc_s.push_back(k);
            if (k >= 61 && k <= 156) begin
                if (vs.line_start) n_ls++;
                if (prev_h_s == 7 && vs.hcount == 4'd0) n_wrap++;
                if ((vs.line_start && prev_ls) || (vs.frame_start && prev_fs) ||
                    (vs.vblank_start && prev_vbs)) n_wide++;
            end
            prev_h_s = int'(vs.hcount);
            prev_ls  = vs.line_start;
            prev_fs  = vs.frame_start;
            prev_vbs = vs.vblank_start;

            if (vp.frame_start && pfc.size() < 5) pfc.push_back(int'(vp.frame_count));
            if (k <= 48 && vp.hsync) begin
                if (int'(vp.hcount) < phs_min) phs_min = int'(vp.hcount);
                if (int'(vp.hcount) > phs_max) phs_max = int'(vp.hcount);
            end

            if (vm.frame_start) mfc.push_back(int'(vm.frame_count));
            if (k <= 800 && !vm.hsync) begin
                if (int'(vm.hcount) < mhs_min) mhs_min = int'(vm.hcount);
                if (int'(vm.hcount) > mhs_max) mhs_max = int'(vm.hcount);
            end
            if (k <= 14400 && !vm.vsync) begin
                if (int'(vm.vcount) < mvs_min) mvs_min = int'(vm.vcount);
                if (int'(vm.vcount) > mvs_max) mvs_max = int'(vm.vcount);
            end
            if (vm.vblank_start && mvb_v < 0) begin
                mvb_h = int'(vm.hcount);
                mvb_v = int'(vm.vcount);
            end

            if (k == rst_k) begin
                chk_val("dflt.rst_h", int'(vd.hcount), 799);
                chk_val("dflt.rst_v", int'(vd.vcount), 521);
                chk_val("dflt.rst_active", int'(vd.active), 0);
                chk_val("dflt.rst_strobes",
                        int'({vd.line_start, vd.frame_start, vd.vblank_start}), 0);
            end
            if (rst_k > 0 && k == rst_k + 1) begin
                chk_val("dflt.post_h", int'(vd.hcount), 0);
                chk_val("dflt.post_v", int'(vd.vcount), 0);
                chk_val("dflt.post_fs", int'(vd.frame_start), 1);
                chk_val("dflt.post_fc", int'(vd.frame_count), 0);
            end
        end

        chk_val("small.fs_count", fs_cyc_s.size(), 2);
        chk_val("small.fs_clk0", (fs_cyc_s.size() > 0) ? fs_cyc_s[0] : -1, 1);
        chk_val("small.fs_clk1", (fs_cyc_s.size() > 1) ? fs_cyc_s[1] : -1, 49);
        chk_val("small.ls_vs_wraps", n_ls, n_wrap);
        chk_val("small.ls_count", n_ls, 6);
        chk_val("small.wide_strobe", n_wide, 0);
        chk_val("pol.fc_count", pfc.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk_val($sformatf("pol.fc_seq%0d", i), (pfc.size() > i) ? pfc[i] : -1, i % 4);
        end
        chk_val("pol.hs_min", phs_min, 5);
        chk_val("pol.hs_max", phs_max, 6);
        chk_val("med.hs_min", mhs_min, 656);
        chk_val("med.hs_max", mhs_max, 751);
        chk_val("med.vs_min", mvs_min, 14);
        chk_val("med.vs_max", mvs_max, 15);
        chk_val("med.vblank_h", mvb_h, 0);
        chk_val("med.vblank_v", mvb_v, 12);
        chk_val("med.fc0", (mfc.size() > 0) ? mfc[0] : -1, 0);
        chk_val("med.fc1", (mfc.size() > 1) ? mfc[1] : -1, 1);
        chk_val("dflt.rst_applied", int'(rst_k > 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
